// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register bridge: FSM state encoding,
// ACK/NACK bus levels and the 3-sample majority helper.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_LOAD,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  // SDA levels during the acknowledge bit
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/i2c_bus_filter.sv
// Synchronizes and glitch-filters SCL/SDA, then derives SCL edges and
// START/STOP conditions from the filtered levels.
module i2c_bus_filter
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync, sda_sync;
  logic [2:0] scl_hist, sda_hist;
  logic       scl, scl_q, sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl      <= 1'b1;
      sda      <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_raw};
      sda_sync <= {sda_sync[0], sda_raw};
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
      scl      <= maj3(scl_hist);
      sda      <= maj3(sda_hist);
      scl_q    <= scl;
      sda_q    <= sda;
    end
  end

  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  // SCL must be high on both samples so a simultaneous SCL/SDA move is not a START/STOP
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_reg_bridge.sv
// I2C slave that maps a pointer byte plus 16-bit data words onto a simple
// register-file strobe interface (auto-incrementing pointer, burst access).
module i2c_reg_bridge
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h40,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe_o,
  output logic              wr_en_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              busy_o
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_bus_filter u_filter (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .scl_raw  (scl_i),
    .sda_raw  (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [7:0]        rx;
  logic [7:0]        rx_next;
  logic [7:0]        hi_byte;
  logic              byte_sel;
  logic [1:0]        ld_phase;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] tx;

  assign rx_next = {rx[6:0], sda};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      sda_oe_o <= 1'b0;
      wr_en_o  <= 1'b0;
      rd_en_o  <= 1'b0;
      busy_o   <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
      bit_cnt  <= '0;
      rx       <= '0;
      hi_byte  <= '0;
      byte_sel <= 1'b0;
      ld_phase <= '0;
      ptr      <= '0;
      tx       <= '0;
    end else begin
      wr_en_o <= 1'b0;
      rd_en_o <= 1'b0;
      if (stop) begin
        state    <= ST_IDLE;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
      end else if (start) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        sda_oe_o <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              rx      <= rx_next;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (rx[7:1] == SLAVE_ADDR) begin
                sda_oe_o <= ~ACK;
                busy_o   <= 1'b1;
                state    <= ST_ADDR_ACK;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          // Reads fetch the word while SCL is high in the ACK bit, so the MSB
          // can be driven on the very fall that ends the ACK.
          ST_ADDR_ACK: begin
            if (scl_rise && rx[0]) begin
              state    <= ST_RD_LOAD;
              ld_phase <= '0;
            end else if (scl_fall) begin
              sda_oe_o <= 1'b0;
              state    <= ST_PTR;
            end
          end
          ST_PTR: begin
            if (scl_rise) begin
              rx      <= rx_next;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              ptr      <= ADDR_W'(rx);
              bit_cnt  <= '0;
              sda_oe_o <= ~ACK;
              state    <= ST_PTR_ACK;
            end
          end
          ST_PTR_ACK: begin
            if (scl_fall) begin
              sda_oe_o <= 1'b0;
              byte_sel <= 1'b0;
              state    <= ST_WR_BYTE;
            end
          end
          ST_WR_BYTE: begin
            if (scl_rise) begin
              rx      <= rx_next;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (byte_sel) begin
                  wr_en_o <= 1'b1;
                  addr_o  <= ptr;
                  wdata_o <= DATA_W'({hi_byte, rx_next});
                  ptr     <= ptr + ADDR_W'(1);
                end else begin
                  hi_byte <= rx_next;
                end
                byte_sel <= ~byte_sel;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt  <= '0;
              sda_oe_o <= ~ACK;
              state    <= ST_WR_ACK;
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              sda_oe_o <= 1'b0;
              state    <= ST_WR_BYTE;
            end
          end
          // rd_en_o in phase 0, rdata_i valid in the cycle after it, captured at its end
          ST_RD_LOAD: begin
            case (ld_phase)
              2'd0: begin
                rd_en_o  <= 1'b1;
                addr_o   <= ptr;
                ld_phase <= 2'd1;
              end
              2'd1: ld_phase <= 2'd2;
              default: begin
                tx       <= rdata_i;
                ptr      <= ptr + ADDR_W'(1);
                bit_cnt  <= '0;
                byte_sel <= 1'b0;
                state    <= ST_RD_BYTE;
              end
            endcase
          end
          ST_RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe_o <= 1'b0;
                bit_cnt  <= '0;
                state    <= ST_RD_ACK;
              end else begin
                sda_oe_o <= ~tx[DATA_W-1];
                tx       <= tx << 1;
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda == NACK) begin
                state <= ST_IGNORE;
              end else if (byte_sel) begin
                state    <= ST_RD_LOAD;
                ld_phase <= '0;
              end else begin
                byte_sel <= 1'b1;
                state    <= ST_RD_BYTE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Directed bench for i2c_reg_bridge: bit-banged I2C master, synchronous
// register-file model and strobe loggers.
module tb_i2c_reg_bridge;

  localparam int unsigned Q = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_oe, wr_en, rd_en, busy;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata = '0;
  logic        sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_reg_bridge #(
    .SLAVE_ADDR (7'h40),
    .ADDR_W     (8),
    .DATA_W     (16)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe_o (sda_oe),
    .wr_en_o  (wr_en),
    .rd_en_o  (rd_en),
    .addr_o   (addr),
    .wdata_o  (wdata),
    .rdata_i  (rdata),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  logic [7:0]  wr_addr_log [16];
  logic [15:0] wr_data_log [16];
  logic [7:0]  rd_addr_log [16];
  int n_cmp = 0, n_err = 0;
  int wr_cnt = 0, rd_cnt = 0, overlap = 0, oe_cnt = 0;

  always @(posedge clk) if (rd_en) rdata <= mem[addr];

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 16) begin
        wr_addr_log[wr_cnt] = addr;
        wr_data_log[wr_cnt] = wdata;
      end
      wr_cnt++;
    end
    if (rd_en) begin
      if (rd_cnt < 16) rd_addr_log[rd_cnt] = addr;
      rd_cnt++;
    end
    if (wr_en && rd_en) overlap++;
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic xfer_bit(input logic b, output logic s);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q();
    s = sda_bus;  wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
    xfer_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, s);
      d[i] = s;
    end
    xfer_bit(mack, s);
  endtask

  // START, address+W, pointer, then n data bytes; the caller issues STOP
  task automatic wr_txn(input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3, input int n, output int nacks);
    logic ack;
    logic [7:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    nacks = 0;
    i2c_start();
    send_byte(8'h80, ack); if (!ack) nacks++;
    send_byte(ptr, ack);   if (!ack) nacks++;
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], ack); if (!ack) nacks++;
    end
  endtask

  initial begin
    int nk, oe0, wr0;
    logic ack, s;
    logic [7:0] b0, b1, b2, b3;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[2] = 16'hBEEF;
    mem[3] = 16'hC0DE;
    mem[4] = 16'hA55A;
    mem[5] = 16'h1111;

    // reset state
    repeat (5) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single word write
    wr_txn(8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 2, nk);
    check("t1_nacks", nk, 0);
    check("t1_busy_mid", busy, 1);
    i2c_stop();
    check("t1_busy_after", busy, 0);
    check("t1_wr_cnt", wr_cnt, 1);
    check("t1_addr", wr_addr_log[0], 8'h03);
    check("t1_wdata", wr_data_log[0], 16'h0001);

    // burst write wrapping the pointer
    wr_txn(8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 4, nk);
    i2c_stop();
    check("t2_nacks", nk, 0);
    check("t2_wr_cnt", wr_cnt, 3);
    check("t2_addr0", wr_addr_log[1], 8'hFF);
    check("t2_wdata0", wr_data_log[1], 16'h1234);
    check("t2_addr1", wr_addr_log[2], 8'h00);
    check("t2_wdata1", wr_data_log[2], 16'h5678);

    // foreign address
    oe0 = oe_cnt;
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'h82, ack);
    check("t3_addr_ack", ack, 0);
    send_byte(8'h00, ack);
    check("t3_busy", busy, 0);
    i2c_stop();
    check("t3_oe_cycles", oe_cnt - oe0, 0);
    check("t3_wr_cnt", wr_cnt - wr0, 0);
    check("t3_rd_cnt", rd_cnt, 0);

    // pointer write, repeated START, burst read
    wr_txn(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 0, nk);
    i2c_start();
    send_byte(8'h81, ack); if (!ack) nk++;
    recv_byte(1'b0, b0);
    recv_byte(1'b0, b1);
    recv_byte(1'b0, b2);
    recv_byte(1'b1, b3);
    i2c_stop();
    check("t4_nacks", nk, 0);
    check("t4_byte0", b0, 8'hA5);
    check("t4_byte1", b1, 8'h5A);
    check("t4_byte2", b2, 8'h11);
    check("t4_byte3", b3, 8'h11);
    check("t4_rd_cnt", rd_cnt, 2);
    check("t4_rd_addr0", rd_addr_log[0], 8'h04);
    check("t4_rd_addr1", rd_addr_log[1], 8'h05);
    check("t4_wr_cnt", wr_cnt, 3);

    // odd byte count discarded; read resumes at that pointer
    wr_txn(8'h02, 8'h12, 8'h00, 8'h00, 8'h00, 1, nk);
    i2c_stop();
    check("t5_nacks", nk, 0);
    check("t5_wr_cnt", wr_cnt, 3);
    i2c_start();
    send_byte(8'h81, ack);
    check("t5_rd_ack", ack, 1);
    recv_byte(1'b1, b0);
    i2c_stop();
    check("t5_byte0", b0, 8'hBE);
    check("t5_rd_cnt", rd_cnt, 3);
    check("t5_rd_addr", rd_addr_log[2], 8'h02);
    // MSB-only read still advanced the pointer
    i2c_start();
    send_byte(8'h81, ack);
    recv_byte(1'b0, b0);
    recv_byte(1'b1, b1);
    i2c_stop();
    check("t5_next_msb", b0, 8'hC0);
    check("t5_next_lsb", b1, 8'hDE);
    check("t5_next_addr", rd_addr_log[3], 8'h03);

    // reset while the slave drives a 0 data bit
    i2c_start();
    send_byte(8'h81, ack);
    xfer_bit(1'b1, s);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    check("t6_oe_before", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("t6_oe_in_rst", sda_oe, 0);
    check("t6_busy_in_rst", busy, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_q();
    scl_m = 1'b0; wait_q();
    i2c_stop();
    wr0 = wr_cnt;
    wr_txn(8'h10, 8'hCA, 8'hFE, 8'h00, 8'h00, 2, nk);
    i2c_stop();
    check("t6_nacks", nk, 0);
    check("t6_wr_cnt", wr_cnt - wr0, 1);
    check("t6_addr", wr_addr_log[wr0], 8'h10);
    check("t6_wdata", wr_data_log[wr0], 16'hCAFE);

    check("strobe_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_reg_bridge.md
I2C_REG_BRIDGE -- requirements
Module: i2c_reg_bridge

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h40: 7-bit I2C device address matched by the bridge.
REQ-002 SHALL have parameter ADDR_W, default 8: register address width.
REQ-003 SHALL have parameter DATA_W, default 16: register data width, carried as two bytes.
REQ-004 SHALL have port clk_i, input, 1: system clock, the only clock; frequency ≥ 16 × SCL.
REQ-005 SHALL have port rst_n_i, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port scl_i, input, 1: I2C clock pin, asynchronous to clk_i.
REQ-007 SHALL have port sda_i, input, 1: I2C data pin, asynchronous to clk_i.
REQ-008 SHALL have port sda_oe_o, output, 1: 1 drives SDA low; 0 releases it (open-drain).
REQ-009 SHALL have port wr_en_o, output, 1: one-cycle register write strobe.
REQ-010 SHALL have port rd_en_o, output, 1: one-cycle register read strobe.
REQ-011 SHALL have port addr_o, output, ADDR_W: register address, valid while wr_en_o or rd_en_o is 1.
REQ-012 SHALL have port wdata_o, output, DATA_W: write data, valid while wr_en_o is 1.
REQ-013 SHALL have port rdata_i, input, DATA_W: register read data, sampled exactly 1 clk_i cycle after rd_en_o.
REQ-014 SHALL have port busy_o, output, 1: 1 from matched address until STOP.

Function
REQ-015 SHALL pass scl_i and sda_i through 2-flop synchronizers, then a 3-sample majority filter; all edge detection SHALL use the filtered signals.
REQ-016 SHALL detect START or repeated START as a filtered SDA fall while filtered SCL is high, and STOP as a filtered SDA rise while filtered SCL is high.
REQ-017 SHALL accept START from any state and go to ADDR; SHALL accept STOP from any state and go to IDLE.
REQ-018 States:
  - IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_ACK, IGNORE.
REQ-019 SHALL sample data bits on the SCL rising edge, MSB first, and change sda_oe_o only in the clk_i cycle after an SCL falling edge.
REQ-020 ADDR SHALL collect 8 bits; on a 7-bit match it SHALL ACK in ADDR_ACK; on a mismatch it SHALL NACK and go to IGNORE until START or STOP.
REQ-021 After ADDR_ACK, R/W=0 SHALL go to PTR and R/W=1 SHALL go to RD_LOAD.
REQ-022 PTR SHALL load the pointer register, ACK, then go to WR_BYTE.
REQ-023 WR_BYTE/WR_ACK SHALL ACK every byte; on the second byte wr_en_o SHALL pulse once, with addr_o = pointer and wdata_o = {byte1, byte2}, within 2 clk_i cycles of the 8th SCL rise; the pointer SHALL then increment.
REQ-024 A STOP or START after an odd number of data bytes SHALL discard the partial word with no wr_en_o.
REQ-025 RD_LOAD SHALL pulse rd_en_o with addr_o = pointer, capture rdata_i 1 cycle later, increment the pointer, and go to RD_BYTE before the next SCL fall.
REQ-026 RD_BYTE SHALL shift out the MSB byte then the LSB byte (sda_oe_o = ~bit) and release SDA during each master ACK bit.
REQ-027 After the LSB byte, master ACK SHALL go to RD_LOAD for the next word; master NACK SHALL release SDA and go to IGNORE.
REQ-028 After the MSB byte, master NACK SHALL end the read (go to IGNORE) with the pointer already incremented.
REQ-029 The pointer SHALL wrap modulo 2^ADDR_W (8'hFF to 8'h00) and SHALL persist across transactions; a read without a preceding pointer write SHALL use the last pointer value.
REQ-030 wr_en_o and rd_en_o SHALL never be 1 in the same cycle.
REQ-031 The block SHALL not stretch SCL.

Reset
REQ-032 While rst_n_i=0: state = IDLE; sda_oe_o, wr_en_o, rd_en_o, busy_o = 0; addr_o, wdata_o, pointer, shift register = 0; synchronizers = 1 (bus idle).
REQ-033 A reset mid-transfer SHALL release SDA immediately; after reset the block SHALL ignore the bus until the next START.

Structure
REQ-034 State encoding and the ACK/NACK constants SHALL reside in shared package i2c_pkg.
REQ-035 The synchronizer, filter and START/STOP/edge detect SHALL be one sub-module i2c_bus_filter; the FSM, shifter and pointer SHALL be in i2c_reg_bridge.

Verification
REQ-036 Write 0x40+W, ptr 0x03, data 0x00,0x01, STOP -> one wr_en_o with addr_o=0x03 and wdata_o=0x0001; ACK on all 4 bytes.
REQ-037 Write ptr 0xFF, data 0x12,0x34,0x56,0x78 -> wr_en_o twice: (0xFF,0x1234) then (0x00,0x5678).
REQ-038 Write ptr 0x04, then Sr, 0x40+R, rdata_i=0xA55A at 0x04 and 0x1111 at 0x05, master ACK,ACK,ACK,NACK -> SDA carries 0xA5,0x5A,0x11,0x11; two rd_en_o pulses.
REQ-039 Address 0x41+W -> NACK, no strobes, sda_oe_o=0 until STOP.
REQ-040 Write ptr 0x02, data 0x12 only, STOP -> no wr_en_o; next read starts at 0x02.
REQ-041 Assert rst_n_i during a read data bit with sda_oe_o=1 -> sda_oe_o=0 immediately; the next complete write transaction succeeds.
